lsu_cache_bridge: RTL

- CPU-side load/store front end that sits directly upstream of the set-associative write-back cache.
- Accepts word requests over a valid/ready handshake and buffers them in a small FIFO.
- Presents one request at a time to the cache, holding address, data and request lines stable while the cache signals miss, then returns read data.
- Keeps hit, miss and stall-cycle statistics for cache-policy evaluation (FIFO vs LRU).

---
 rtl/lsu_cache_pkg.sv | 15 +
 rtl/lsu_req_fifo.sv | 46 ++++
 rtl/lsu_cache_bridge.sv | 127 ++++++++++++
 3 files changed

// File: rtl/lsu_cache_pkg.sv
// Shared types and default sizing for the LSU-to-cache bridge.
package lsu_cache_pkg;

   localparam int DEF_QUEUE_DEPTH = 4;
   localparam int DEF_CNT_WIDTH   = 32;

   typedef enum logic [1:0] {IDLE, ISSUE, RESP} bridge_state_t;

   typedef struct packed {
      logic        we;
      logic [31:0] addr;
      logic [31:0] wdata;
   } lsu_req_t;

endpackage

// File: rtl/lsu_req_fifo.sv
// Request queue between the CPU handshake and the cache issue logic.
module lsu_req_fifo
   import lsu_cache_pkg::*;
#(
   parameter int DEPTH = DEF_QUEUE_DEPTH,
   localparam int AW   = $clog2(DEPTH)
) (
   input  logic          clk,
   input  logic          rst,
   input  logic          push,
   input  logic          pop,
   input  lsu_req_t      din,
   output logic          full,
   output logic          empty,
   output lsu_req_t      head,
   output logic [AW:0]   count
);

   lsu_req_t          r_mem [DEPTH];
   logic [AW-1:0]     r_wptr;
   logic [AW-1:0]     r_rptr;
   logic [AW:0]       r_count;

   assign full  = (r_count == (AW+1)'(DEPTH));
   assign empty = (r_count == '0);
   assign head  = r_mem[r_rptr];
   assign count = r_count;

   // Pointers wrap naturally because DEPTH is a power of two.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_wptr  <= '0;
         r_rptr  <= '0;
         r_count <= '0;
      end else begin
         if (push) r_wptr <= r_wptr + AW'(1);
         if (pop)  r_rptr <= r_rptr + AW'(1);
         r_count <= r_count + (AW+1)'(push) - (AW+1)'(pop);
      end
   end

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wptr] <= din;
   end

endmodule

// File: rtl/lsu_cache_bridge.sv
// Load/store front end: queues CPU word requests and presents them one at a
// time to the write-back cache, returning load data and keeping hit/miss stats.
module lsu_cache_bridge
   import lsu_cache_pkg::*;
#(
   parameter int QUEUE_DEPTH = DEF_QUEUE_DEPTH,
   parameter int CNT_WIDTH   = DEF_CNT_WIDTH
) (
   input  logic                 clk,
   input  logic                 rst,
   input  logic                 req_valid,
   output logic                 req_ready,
   input  logic                 req_we,
   input  logic [31:0]          req_addr,
   input  logic [31:0]          req_wdata,
   output logic                 resp_valid,
   output logic [31:0]          resp_rdata,
   output logic [31:0]          cache_addr,
   output logic                 cache_rd_req,
   output logic                 cache_wr_req,
   output logic [31:0]          cache_wr_data,
   input  logic                 cache_miss,
   input  logic [31:0]          cache_rd_data,
   output logic [CNT_WIDTH-1:0] hit_cnt,
   output logic [CNT_WIDTH-1:0] miss_cnt,
   output logic [CNT_WIDTH-1:0] stall_cnt
);

   localparam int AW = $clog2(QUEUE_DEPTH);

   bridge_state_t        r_state;
   bridge_state_t        w_state_nxt;
   logic                 r_first;
   logic                 r_resp_valid;
   logic [31:0]          r_resp_rdata;
   logic [CNT_WIDTH-1:0] r_hit_cnt;
   logic [CNT_WIDTH-1:0] r_miss_cnt;
   logic [CNT_WIDTH-1:0] r_stall_cnt;

   logic                 w_push;
   logic                 w_pop;
   logic                 w_full;
   logic                 w_empty;
   logic                 w_avail;
   logic                 w_more;
   lsu_req_t             w_din;
   lsu_req_t             w_head;
   logic [AW:0]          w_count;

   assign req_ready = !w_full;
   assign w_push    = req_valid && !w_full;
   assign w_pop     = (r_state == ISSUE) && !cache_miss;
   assign w_din     = {req_we, req_addr, req_wdata};
   // "Non-empty after this edge": a same-cycle push counts, which is what lets
   // stores stream at one per cycle and a fresh request issue the next cycle.
   assign w_avail   = !w_empty || w_push;
   assign w_more    = (w_count > (AW+1)'(1)) || w_push;

   assign resp_valid = r_resp_valid;
   assign resp_rdata = r_resp_rdata;
   assign hit_cnt    = r_hit_cnt;
   assign miss_cnt   = r_miss_cnt;
   assign stall_cnt  = r_stall_cnt;

   lsu_req_fifo #(.DEPTH(QUEUE_DEPTH)) u_fifo (
      .clk   (clk),
      .rst   (rst),
      .push  (w_push),
      .pop   (w_pop),
      .din   (w_din),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head),
      .count (w_count)
   );

   always_comb begin
      w_state_nxt   = r_state;
      cache_addr    = '0;
      cache_wr_data = '0;
      cache_rd_req  = 1'b0;
      cache_wr_req  = 1'b0;
      case (r_state)
         IDLE: begin
            if (w_avail) w_state_nxt = ISSUE;
         end
         ISSUE: begin
            cache_addr    = w_head.addr;
            cache_wr_data = w_head.wdata;
            cache_rd_req  = !w_head.we;
            cache_wr_req  = w_head.we;
            if (!cache_miss) begin
               if (w_head.we) w_state_nxt = w_more ? ISSUE : IDLE;
               else           w_state_nxt = RESP;
            end
         end
         RESP: begin
            w_state_nxt = w_avail ? ISSUE : IDLE;
         end
         default: w_state_nxt = IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         r_state      <= IDLE;
         r_first      <= 1'b0;
         r_resp_valid <= 1'b0;
         r_resp_rdata <= '0;
         r_hit_cnt    <= '0;
         r_miss_cnt   <= '0;
         r_stall_cnt  <= '0;
      end else begin
         r_state      <= w_state_nxt;
         // A new presentation starts whenever ISSUE is entered other than by stalling.
         r_first      <= (w_state_nxt == ISSUE) && !((r_state == ISSUE) && cache_miss);
         r_resp_valid <= (r_state == RESP);
         if (r_state == RESP) r_resp_rdata <= cache_rd_data;
         if ((r_state == ISSUE) && r_first) begin
            if (cache_miss) r_miss_cnt <= r_miss_cnt + CNT_WIDTH'(1);
            else            r_hit_cnt  <= r_hit_cnt + CNT_WIDTH'(1);
         end
         if ((r_state == ISSUE) && cache_miss) r_stall_cnt <= r_stall_cnt + CNT_WIDTH'(1);
      end
   end

endmodule
